// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle MIPS-subset core.
package mc_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU control encoding
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select: B register, constant 4, extended imm, branch offset
    localparam logic [1:0] SRCB_B   = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;
    localparam logic [1:0] SRCB_BR  = 2'd3;

    // PC next-value select
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    function automatic logic funct_ok(input logic [5:0] fn);
        return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Control FSM: sequences each instruction and decodes datapath enables.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       mdr_write_o,
    output logic       ab_write_o,
    output logic       aluout_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_ctl_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       instr_done_o,
    output logic       halted_o
);

    state_e state_q, state_d;

    // Memory request lines depend on state only; reset kills an in-flight request at once.
    assign mem_req_o = !rst_i && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR);
    assign mem_we_o  = (state_q == S_MEMWR);
    assign iord_o    = (state_q == S_MEMRD || state_q == S_MEMWR);
    assign halted_o  = (state_q == S_HALT);

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and datapath enable decode
    always_comb begin
        state_d        = state_q;
        pc_write_o     = 1'b0;
        pc_src_o       = PCSRC_ALU;
        ir_write_o     = 1'b0;
        mdr_write_o    = 1'b0;
        ab_write_o     = 1'b0;
        aluout_write_o = 1'b0;
        reg_write_o    = 1'b0;
        reg_dst_o      = 1'b0;
        mem_to_reg_o   = 1'b0;
        alu_src_a_o    = 1'b0;
        alu_src_b_o    = SRCB_B;
        alu_ctl_o      = ALU_ADD;
        instr_done_o   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b_o = SRCB_4;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                ab_write_o     = 1'b1;
                aluout_write_o = 1'b1;
                alu_src_b_o    = SRCB_BR;
                case (op_i)
                    OP_LW, OP_SW:               state_d = S_MEMADR;
                    OP_RTYPE:                   state_d = funct_ok(funct_i) ? S_EXEC : S_HALT;
                    OP_ADDI, OP_ANDI, OP_ORI:   state_d = S_IEXEC;
                    OP_BEQ:                     state_d = S_BRANCH;
                    OP_J:                       state_d = S_JUMP;
                    default:                    state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o    = 1'b1;
                alu_src_b_o    = SRCB_IMM;
                aluout_write_o = 1'b1;
                state_d        = (op_i == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_ready_i) begin
                    mdr_write_o = 1'b1;
                    state_d     = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready_i) begin
                    instr_done_o = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a_o    = 1'b1;
                alu_ctl_o      = funct_alu(funct_i);
                aluout_write_o = 1'b1;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a_o    = 1'b1;
                alu_src_b_o    = SRCB_IMM;
                alu_ctl_o      = (op_i == OP_ANDI) ? ALU_AND : (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
                aluout_write_o = 1'b1;
                state_d        = S_IWB;
            end
            S_IWB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_ctl_o    = ALU_SUB;
                pc_src_o     = PCSRC_ALUOUT;
                pc_write_o   = zero_i;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                pc_src_o     = PCSRC_JUMP;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

endmodule

// File: rtl/mc_core.sv
// Multicycle MIPS-subset core: architectural registers, register file and ALU.
module mc_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter bit          ZEXT_LOGIC = 1'b1
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemReady,
    output logic [31:0] PC,
    output logic        InstrDone,
    output logic        Halted
);

    logic [31:0] pc_q, pc_d, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0] rf_q [32];
    logic        pc_write, ir_write, mdr_write, ab_write, aluout_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a, iord, zero;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_ctl;
    logic [31:0] sign_imm, ext_imm, src_a, src_b, alu_y, rf_a, rf_b, wr_data;
    logic [4:0]  wr_addr;

    wire [5:0] op = ir_q[31:26];
    wire [4:0] rs = ir_q[25:21];
    wire [4:0] rt = ir_q[20:16];
    wire [4:0] rd = ir_q[15:11];

    mc_ctrl u_ctrl (
        .clk_i          (CLK),
        .rst_i          (Reset),
        .op_i           (op),
        .funct_i        (ir_q[5:0]),
        .mem_ready_i    (MemReady),
        .zero_i         (zero),
        .pc_write_o     (pc_write),
        .pc_src_o       (pc_src),
        .ir_write_o     (ir_write),
        .mdr_write_o    (mdr_write),
        .ab_write_o     (ab_write),
        .aluout_write_o (aluout_write),
        .reg_write_o    (reg_write),
        .reg_dst_o      (reg_dst),
        .mem_to_reg_o   (mem_to_reg),
        .alu_src_a_o    (alu_src_a),
        .alu_src_b_o    (alu_src_b),
        .alu_ctl_o      (alu_ctl),
        .mem_req_o      (MemReq),
        .mem_we_o       (MemWe),
        .iord_o         (iord),
        .instr_done_o   (InstrDone),
        .halted_o       (Halted)
    );

    assign MemAddr  = iord ? aluout_q : pc_q;
    assign MemWData = b_q;
    assign PC       = pc_q;

    // Immediate extension: only andi/ori may zero-extend, address and addi math always sign-extends.
    assign sign_imm = {{16{ir_q[15]}}, ir_q[15:0]};
    assign ext_imm  = (ZEXT_LOGIC && (op == OP_ANDI || op == OP_ORI)) ? {16'h0, ir_q[15:0]} : sign_imm;

    // Register file read ports; $0 is hardwired to zero.
    assign rf_a    = (rs == 5'd0) ? 32'h0 : rf_q[rs];
    assign rf_b    = (rt == 5'd0) ? 32'h0 : rf_q[rt];
    assign wr_addr = reg_dst ? rd : rt;
    assign wr_data = mem_to_reg ? mdr_q : aluout_q;

    // ALU operand muxes and function
    always_comb begin
        src_a = alu_src_a ? a_q : pc_q;
        case (alu_src_b)
            SRCB_B:   src_b = b_q;
            SRCB_4:   src_b = 32'd4;
            SRCB_IMM: src_b = ext_imm;
            default:  src_b = {sign_imm[29:0], 2'b00};
        endcase
        case (alu_ctl)
            ALU_AND: alu_y = src_a & src_b;
            ALU_OR:  alu_y = src_a | src_b;
            ALU_SUB: alu_y = src_a - src_b;
            ALU_SLT: alu_y = {31'h0, $signed(src_a) < $signed(src_b)};
            default: alu_y = src_a + src_b;
        endcase
        zero = (alu_y == 32'h0);
    end

    // Next PC: sequential increment, branch target held in ALUOut, or jump target
    always_comb begin
        case (pc_src)
            PCSRC_ALU:    pc_d = alu_y;
            PCSRC_ALUOUT: pc_d = aluout_q;
            PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
            default:      pc_d = pc_q;
        endcase
    end

    // Architectural registers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0;
            mdr_q    <= 32'h0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            aluout_q <= 32'h0;
        end else begin
            if (pc_write)     pc_q     <= pc_d;
            if (ir_write)     ir_q     <= MemRData;
            if (mdr_write)    mdr_q    <= MemRData;
            if (ab_write)     a_q      <= rf_a;
            if (ab_write)     b_q      <= rf_b;
            if (aluout_write) aluout_q <= alu_y;
        end
    end

    // Register file write port; contents survive reset, writes to $0 dropped
    always_ff @(posedge CLK) begin
        if (reg_write && wr_addr != 5'd0) rf_q[wr_addr] <= wr_data;
    end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core with a scoreboard on stores and retirements.
module tb_mc_core;

    logic        CLK, Reset;
    logic        MemReq, MemWe, MemReady, InstrDone, Halted;
    logic [31:0] MemAddr, MemWData, MemRData, PC;
    logic        MemReq2, MemWe2, InstrDone2, Halted2;
    logic [31:0] MemAddr2, MemWData2, MemRData2, PC2;

    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } st_t;
    typedef struct { int cyc; logic [31:0] pc; } dn_t;
    st_t exp_st[$];
    dn_t exp_dn[$];

    int total, bad, z0_stores;
    int cyc, wcnt, cur_wait;
    int fetch_wait, rd_wait, wr_wait;
    int load_seq, seen_seq;
    logic [31:0] mem [256];
    logic [31:0] img [256];

    mc_core dut (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady), .PC(PC),
        .InstrDone(InstrDone), .Halted(Halted)
    );

    mc_core #(.RESET_PC(32'h0), .ZEXT_LOGIC(1'b0)) dut_z0 (
        .CLK(CLK), .Reset(Reset), .MemReq(MemReq2), .MemWe(MemWe2), .MemAddr(MemAddr2),
        .MemWData(MemWData2), .MemRData(MemRData2), .MemReady(1'b1), .PC(PC2),
        .InstrDone(InstrDone2), .Halted(Halted2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Unified memory with per-access-type wait states
    always_comb begin
        if (MemWe)              cur_wait = wr_wait;
        else if (MemAddr != PC) cur_wait = rd_wait;
        else                    cur_wait = fetch_wait;
    end
    assign MemReady = (wcnt >= cur_wait);
    assign MemRData = mem[MemAddr[9:2]];

    always @(posedge CLK) begin
        if (load_seq != seen_seq) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            seen_seq <= load_seq;
            wcnt     <= 0;
        end else if (MemReq && !MemReady) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
            if (MemReq && MemWe) mem[MemAddr[9:2]] <= MemWData;
        end
    end

    // Zero-wait ROM for the sign-extending instance: ori $8,$0,0xFFFF; sw $8,0x4C($0); loop
    always_comb begin
        case (MemAddr2)
            32'h0:   MemRData2 = 32'h3408FFFF;
            32'h4:   MemRData2 = 32'hAC08004C;
            32'h8:   MemRData2 = 32'h1000FFFF;
            default: MemRData2 = 32'h0;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        st_t s;
        dn_t d;
        forever begin
            @(negedge CLK);
            if (!Reset && MemReq && MemReady && MemWe) begin
                if (exp_st.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_store: addr %h data %h", MemAddr, MemWData);
                end else begin
                    s = exp_st.pop_front();
                    chk("store_addr", MemAddr, s.addr);
                    chk("store_data", MemWData, s.data);
                    chk("store_cycle", 32'(cyc + 1), 32'(s.cyc));
                end
            end
            if (!Reset && InstrDone && exp_dn.size() != 0) begin
                d = exp_dn.pop_front();
                chk("done_cycle", 32'(cyc + 1), 32'(d.cyc));
                chk("done_pc", PC, d.pc);
            end
            if (!Reset && MemReq2 && MemWe2) begin
                chk("z0_store_addr", MemAddr2, 32'h4C);
                chk("z0_store_data", MemWData2, 32'hFFFF_FFFF);
                z0_stores++;
            end
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 32'h0;
    endtask

    task automatic load_prog_a();
        logic [31:0] p [37];
        clear_img();
        p = '{32'h20010005, 32'h2002FFFD, 32'h00221820, 32'hAC030040, 32'h8C040040,
              32'hAC040044, 32'h8C050060, 32'h20060001, 32'h00A6382A, 32'hAC070048,
              32'h3408FFFF, 32'hAC08004C, 32'h20000007, 32'hAC000050, 32'h10220005,
              32'h08000020,
              32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h80000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
              32'h00225022, 32'hAC0A0054, 32'h310900F0, 32'hAC090058, 32'h1021FFFF};
        for (int i = 0; i < 37; i++) img[i] = p[i];
        load_seq++;
    endtask

    // Reset must already be asserted; the image copy happens on a reset-time edge.
    task automatic release_reset();
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    initial begin
        int dn_c [24];
        logic [31:0] dn_p [24];
        total = 0; bad = 0; z0_stores = 0;
        Reset = 1'b1;
        fetch_wait = 0; rd_wait = 0; wr_wait = 0;
        load_seq = 0; seen_seq = 0;
        fork monitor(); join_none

        // Reset state, then a first fetch stalled for three cycles
        load_prog_a();
        fetch_wait = 3;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_memreq", 32'(MemReq), 32'h0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_done", 32'(InstrDone), 32'h0);
        chk("rst_halted", 32'(Halted), 32'h0);
        Reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge CLK);
            chk("stall_req", 32'(MemReq), 32'h1);
            chk("stall_addr", MemAddr, 32'h0);
            chk("stall_pc", PC, 32'h0);
        end
        @(negedge CLK);
        chk("stall_pc_pre_hs", PC, 32'h0);
        @(posedge CLK);
        #1 chk("stall_pc_post_hs", PC, 32'h4);

        // Main program, zero-wait fetch/write, two-cycle data reads
        Reset = 1'b1;
        fetch_wait = 0; rd_wait = 2; wr_wait = 0;
        load_prog_a();
        exp_st.push_back('{32'h40, 32'h2, 16});
        exp_st.push_back('{32'h44, 32'h2, 27});
        exp_st.push_back('{32'h48, 32'h1, 46});
        exp_st.push_back('{32'h4C, 32'h0000FFFF, 54});
        exp_st.push_back('{32'h50, 32'h0, 62});
        exp_st.push_back('{32'h54, 32'h8, 76});
        exp_st.push_back('{32'h58, 32'hF0, 84});
        dn_c = '{4, 8, 12, 16, 23, 27, 34, 38, 42, 46, 50, 54, 58, 62, 65, 68, 72, 76, 80, 84, 87, 90, 93, 96};
        dn_p = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28,
                 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h84, 32'h88, 32'h8C, 32'h90,
                 32'h94, 32'h94, 32'h94, 32'h94};
        for (int i = 0; i < 24; i++) exp_dn.push_back('{dn_c[i], dn_p[i]});
        release_reset();
        for (int i = 0; i < 300 && (exp_dn.size() != 0 || exp_st.size() != 0); i++) @(posedge CLK);
        #1;
        chk("prog_a_drained", 32'(exp_dn.size() + exp_st.size()), 32'h0);
        chk("beq_loop_pc", PC, 32'h90);
        chk("prog_a_not_halted", 32'(Halted), 32'h0);
        chk("z0_store_seen", 32'(z0_stores), 32'h1);
        repeat (3) @(posedge CLK);
        #1 chk("beq_loop_pc_again", PC, 32'h90);

        // Unsupported opcode halts the core
        Reset = 1'b1;
        rd_wait = 0;
        clear_img();
        img[0] = 32'h20010001;
        img[1] = 32'hFC000000;
        load_seq++;
        exp_dn.push_back('{4, 32'h4});
        release_reset();
        for (int i = 0; i < 50 && !Halted; i++) @(posedge CLK);
        #1 chk("halted", 32'(Halted), 32'h1);
        chk("halt_done_seen", 32'(exp_dn.size()), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("halt_no_req", 32'(MemReq), 32'h0);
            chk("halt_sticky", 32'(Halted), 32'h1);
        end

        // Reset during a stalled store: request drops, memory untouched, refetch from RESET_PC
        Reset = 1'b1;
        wr_wait = 5;
        clear_img();
        img[0]  = 32'hAC010070;
        img[28] = 32'hDEADBEEF;
        load_seq++;
        release_reset();
        repeat (4) @(negedge CLK);
        chk("memwr_req", 32'(MemReq), 32'h1);
        chk("memwr_we", 32'(MemWe), 32'h1);
        chk("memwr_addr", MemAddr, 32'h70);
        #1 Reset = 1'b1;
        #1 chk("rst_drops_req", 32'(MemReq), 32'h0);
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("refetch_req", 32'(MemReq), 32'h1);
        chk("refetch_addr", MemAddr, 32'h0);
        chk("refetch_we", 32'(MemWe), 32'h0);
        chk("store_abandoned", mem[28], 32'hDEADBEEF);
        chk("queues_empty", 32'(exp_dn.size() + exp_st.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
